vga_scan_engine: RTL

- Parametrised successor to the fixed 640x480 VGA controller/timing pair.
- Generates a pixel-clock enable from the system clock, full H/V timing from parameters, and an incremental framebuffer address with optional power-of-two pixel replication.
- Delays sync/active by a configurable pipeline latency so they line up with the image RAM -> palette RAM read chain.
- Sits between the system clock domain and the framebuffer/palette RAMs; drives the VGA pins directly.

---
 rtl/vga_scan_engine.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vga_scan_engine.sv
// rtl/vga_scan_engine.sv - parametrised VGA timing, framebuffer addressing and RAM-latency-aligned outputs
module vga_scan_engine #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SYNC_POL    = 0,
   parameter int CLK_DIV     = 4,
   parameter int PIPE_LAT    = 2,
   parameter int SCALE_SHIFT = 0,
   parameter int ADDR_WIDTH  = 19,
   parameter int COLOR_BITS  = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [COLOR_BITS-1:0] pix_data,
   output logic                  pix_en,
   output logic [ADDR_WIDTH-1:0] fb_addr,
   output logic [9:0]            x,
   output logic [9:0]            y,
   output logic                  hSync,
   output logic                  vSync,
   output logic                  active,
   output logic [COLOR_BITS-1:0] rgb,
   output logic                  frame_end
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] X_LAST      = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_ACT       = 10'(H_ACTIVE);
   localparam logic [9:0] Y_ACT       = 10'(V_ACTIVE);
   localparam logic [9:0] Y_BASE_LAST = 10'(V_ACTIVE - 1);
   localparam logic [9:0] HS_LO       = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_HI       = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_LO       = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_HI       = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   // Low bits of x/y that select a screen pixel inside one replicated framebuffer pixel
   localparam logic [9:0] SCALE_MASK  = 10'((1 << SCALE_SHIFT) - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(H_ACTIVE >> SCALE_SHIFT);
   localparam logic SYNC_ON = (SYNC_POL != 0);

   logic [DIV_W-1:0]      div_cnt;
   logic [DIV_W-1:0]      div_next;
   logic [ADDR_WIDTH-1:0] line_base;
   logic [9:0]            x_inc;
   logic                  x_last;
   logic                  y_last;
   logic                  base_step;
   logic                  addr_step;
   logic                  raw_active;
   logic                  raw_hsync;
   logic                  raw_vsync;
   logic [2:0]            raw_vec;
   logic [2:0]            tap;

   // Next-state helpers and undelayed timing flags derived from the scan position
   always_comb begin
      div_next   = (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);
      x_inc      = x + 10'd1;
      x_last     = (x == X_LAST);
      y_last     = (y == Y_LAST);
      base_step  = ((y & SCALE_MASK) == SCALE_MASK) && (y < Y_BASE_LAST);
      addr_step  = (x_inc < X_ACT) && ((x_inc & SCALE_MASK) == 10'd0);
      raw_active = (x < X_ACT) && (y < Y_ACT);
      raw_hsync  = (x >= HS_LO) && (x <= HS_HI);
      raw_vsync  = (y >= VS_LO) && (y <= VS_HI);
      raw_vec    = {raw_active, raw_hsync, raw_vsync};
   end

   // Pixel-tick divider; pix_en is registered so it is high exactly while div_cnt is at its top
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         pix_en  <= 1'b0;
      end else begin
         div_cnt <= div_next;
         pix_en  <= (div_next == DIV_MAX);
      end
   end

   // Scan counters and incremental framebuffer address (line base advances once per replicated line)
   always_ff @(posedge clk) begin
      if (reset) begin
         x         <= '0;
         y         <= '0;
         line_base <= '0;
         fb_addr   <= '0;
      end else if (pix_en) begin
         if (x_last) begin
            x <= '0;
            if (y_last) begin
               y         <= '0;
               line_base <= '0;
               fb_addr   <= '0;
            end else begin
               y <= y + 10'd1;
               if (base_step) begin
                  line_base <= line_base + LINE_STRIDE;
                  fb_addr   <= line_base + LINE_STRIDE;
               end else begin
                  fb_addr <= line_base;
               end
            end
         end else begin
            x <= x_inc;
            if (addr_step) begin
               fb_addr <= fb_addr + ADDR_WIDTH'(1);
            end
         end
      end
   end

   generate
      if (PIPE_LAT == 0) begin : g_direct
         assign tap = raw_vec;
      end else begin : g_delay
         logic [2:0] stage [PIPE_LAT];

         // Delay timing flags by the RAM read latency so they meet pix_data
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < PIPE_LAT; i++) begin
                  stage[i] <= '0;
               end
            end else if (pix_en) begin
               stage[0] <= raw_vec;
               for (int i = 1; i < PIPE_LAT; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign tap = stage[PIPE_LAT-1];
      end
   endgenerate

   // Output register: colour and sync/active leave the block on the same tick
   always_ff @(posedge clk) begin
      if (reset) begin
         active <= 1'b0;
         hSync  <= ~SYNC_ON;
         vSync  <= ~SYNC_ON;
         rgb    <= '0;
      end else if (pix_en) begin
         active <= tap[2];
         hSync  <= tap[1] ? SYNC_ON : ~SYNC_ON;
         vSync  <= tap[0] ? SYNC_ON : ~SYNC_ON;
         rgb    <= tap[2] ? pix_data : '0;
      end
   end

   assign frame_end = pix_en && x_last && y_last;

endmodule
